// File: rtl/genius_game_ctrl.sv
// Simon-style memory game controller: grows a random colour sequence, plays it back
// on a one-hot LED, then checks the player's button presses against it.
module genius_game_ctrl #(
  parameter int MAX_LEN        = 16,
  parameter int ON_CYCLES      = 25000000,
  parameter int OFF_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] color,
  input  logic       b_blue,
  input  logic       b_yellow,
  input  logic       b_green,
  input  logic       b_red,
  input  logic       b_power,
  output logic [3:0] led,
  output logic [4:0] level,
  output logic       listening,
  output logic       win,
  output logic       game_over
);

  localparam int TMAX_A = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE
  } state_t;

  state_t        state, state_n;
  logic [4:0]    len, len_n;
  logic [4:0]    idx, idx_n;
  logic [TW-1:0] timer, timer_n;
  logic          seq_we;
  logic [1:0]    seq [MAX_LEN];

  logic [3:0] btn;
  logic       press_valid;
  logic [1:0] press_color;
  logic [1:0] cur_color;
  logic       last_step;

  assign btn         = {b_red, b_green, b_yellow, b_blue};
  assign press_valid = $onehot(btn);
  assign cur_color   = seq[idx[IW-1:0]];
  assign last_step   = (idx == len - 5'd1);

  always_comb begin
    press_color = 2'd0;
    if (b_yellow) press_color = 2'd1;
    if (b_green)  press_color = 2'd2;
    if (b_red)    press_color = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      len   <= len_n;
      idx   <= idx_n;
      timer <= timer_n;
    end
  end

  // Sequence RAM has no reset; its contents only matter once written by ADD.
  always_ff @(posedge clk) begin
    if (seq_we && !rst) seq[len[IW-1:0]] <= color;
  end

  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    timer_n = timer;
    seq_we  = 1'b0;
    case (state)
      IDLE: begin
        if (b_power) begin
          state_n = ADD;
          len_n   = '0;
          idx_n   = '0;
          timer_n = '0;
        end
      end
      ADD: begin
        seq_we  = 1'b1;
        len_n   = len + 5'd1;
        idx_n   = '0;
        timer_n = '0;
        state_n = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer == TW'(ON_CYCLES - 1)) begin
          timer_n = '0;
          state_n = SHOW_OFF;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      SHOW_OFF: begin
        if (timer == TW'(OFF_CYCLES - 1)) begin
          timer_n = '0;
          if (last_step) begin
            idx_n   = '0;
            state_n = WAIT_IN;
          end else begin
            idx_n   = idx + 5'd1;
            state_n = SHOW_ON;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WAIT_IN: begin
        // A valid press in the final cycle wins over the timeout.
        if (press_valid) begin
          timer_n = '0;
          if (press_color != cur_color) begin
            state_n = LOSE;
          end else if (last_step) begin
            state_n = (len == 5'(MAX_LEN)) ? WIN : ADD;
          end else begin
            idx_n = idx + 5'd1;
          end
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = LOSE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WIN, LOSE: ;
      default: state_n = IDLE;
    endcase
    if (b_power && state != IDLE) begin
      state_n = IDLE;
      len_n   = '0;
      idx_n   = '0;
      timer_n = '0;
      seq_we  = 1'b0;
    end
  end

  always_comb begin
    led = 4'b0000;
    if (state == SHOW_ON) led = 4'b0001 << cur_color;
    if (state == WIN)     led = 4'b1111;
  end

  assign level     = len;
  assign listening = (state == WAIT_IN);
  assign win       = (state == WIN);
  assign game_over = (state == LOSE);

endmodule

// File: tb/tb_genius_game_ctrl.sv
// Directed bench for genius_game_ctrl with short timing parameters; inputs change
// and outputs are sampled on the falling edge.
module tb_genius_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] color;
  logic       b_blue, b_yellow, b_green, b_red, b_power;
  logic [3:0] led;
  logic [4:0] level;
  logic       listening, win, game_over;

  int checks = 0;
  int errors = 0;

  genius_game_ctrl #(
    .MAX_LEN(2), .ON_CYCLES(3), .OFF_CYCLES(2), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .color(color),
    .b_blue(b_blue), .b_yellow(b_yellow), .b_green(b_green), .b_red(b_red),
    .b_power(b_power),
    .led(led), .level(level), .listening(listening), .win(win), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // btn order is {red, green, yellow, blue}; press pulses last one clock.
  task automatic applyStimulus(input logic pwr, input logic [3:0] btn, input logic [1:0] col);
    b_power = pwr;
    {b_red, b_green, b_yellow, b_blue} = btn;
    color = col;
    @(negedge clk);
    b_power = 1'b0;
    {b_red, b_green, b_yellow, b_blue} = 4'b0000;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'b0000, color);
  endtask

  task automatic startGame(input logic [1:0] col);
    applyStimulus(1'b1, 4'b0000, col);
    idleCycles(6);
  endtask

  logic [3:0] show_exp [9];

  initial begin
    show_exp = '{4'b0100, 4'b0100, 4'b0000, 4'b0000,
                 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    rst = 1'b1;
    color = 2'b00;
    {b_power, b_red, b_green, b_yellow, b_blue} = 5'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_led", 8'(led), 8'h0);
    checkOutput("rst_level", 8'(level), 8'h0);
    checkOutput("rst_listen", 8'(listening), 8'h0);
    checkOutput("rst_win", 8'(win), 8'h0);
    checkOutput("rst_over", 8'(game_over), 8'h0);

    // First round: green shown for 3 clocks, dark for 2, then listening.
    applyStimulus(1'b1, 4'b0000, 2'b10);
    checkOutput("add_led", 8'(led), 8'h0);
    applyStimulus(1'b0, 4'b0000, 2'b10);
    checkOutput("on1_led", 8'(led), 8'h4);
    checkOutput("on1_level", 8'(level), 8'h1);
    applyStimulus(1'b0, 4'b0000, 2'b10);
    checkOutput("on2_led", 8'(led), 8'h4);
    applyStimulus(1'b0, 4'b0000, 2'b10);
    checkOutput("on3_led", 8'(led), 8'h4);
    applyStimulus(1'b0, 4'b0000, 2'b10);
    checkOutput("off1_led", 8'(led), 8'h0);
    applyStimulus(1'b0, 4'b0000, 2'b10);
    checkOutput("off2_listen", 8'(listening), 8'h0);
    applyStimulus(1'b0, 4'b0000, 2'b10);
    checkOutput("wait_listen", 8'(listening), 8'h1);
    checkOutput("wait_level", 8'(level), 8'h1);

    // Two buttons at once are ignored.
    applyStimulus(1'b0, 4'b1001, 2'b10);
    checkOutput("dual_listen", 8'(listening), 8'h1);
    checkOutput("dual_over", 8'(game_over), 8'h0);

    // Correct green, yellow appended, full playback, then green+yellow wins.
    applyStimulus(1'b0, 4'b0100, 2'b01);
    checkOutput("r1_add_listen", 8'(listening), 8'h0);
    applyStimulus(1'b0, 4'b0000, 2'b01);
    checkOutput("r2_on_led", 8'(led), 8'h4);
    checkOutput("r2_level", 8'(level), 8'h2);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 4'b0000, 2'b01);
      checkOutput($sformatf("r2_show%0d", i), 8'(led), 8'(show_exp[i]));
    end
    applyStimulus(1'b0, 4'b0000, 2'b01);
    checkOutput("r2_listen", 8'(listening), 8'h1);
    applyStimulus(1'b0, 4'b0100, 2'b01);
    checkOutput("r2_p1_listen", 8'(listening), 8'h1);
    applyStimulus(1'b0, 4'b0010, 2'b01);
    checkOutput("win_flag", 8'(win), 8'h1);
    checkOutput("win_led", 8'(led), 8'hf);
    checkOutput("win_level", 8'(level), 8'h2);
    idleCycles(3);
    checkOutput("win_hold", 8'(win), 8'h1);
    applyStimulus(1'b1, 4'b0000, 2'b00);
    checkOutput("win_pwr_level", 8'(level), 8'h0);
    checkOutput("win_pwr_win", 8'(win), 8'h0);

    // Wrong colour loses immediately.
    startGame(2'b10);
    checkOutput("g2_listen", 8'(listening), 8'h1);
    applyStimulus(1'b0, 4'b1000, 2'b00);
    checkOutput("lose_over", 8'(game_over), 8'h1);
    checkOutput("lose_listen", 8'(listening), 8'h0);
    checkOutput("lose_level", 8'(level), 8'h1);
    applyStimulus(1'b1, 4'b0000, 2'b00);
    checkOutput("lose_pwr", 8'(game_over), 8'h0);

    // Timeout after 20 idle clocks in WAIT_IN.
    startGame(2'b10);
    idleCycles(19);
    checkOutput("to19_listen", 8'(listening), 8'h1);
    checkOutput("to19_over", 8'(game_over), 8'h0);
    idleCycles(1);
    checkOutput("to20_over", 8'(game_over), 8'h1);
    applyStimulus(1'b1, 4'b0000, 2'b00);

    // Correct press on the 20th clock beats the timeout.
    startGame(2'b10);
    idleCycles(19);
    applyStimulus(1'b0, 4'b0100, 2'b11);
    checkOutput("late_over", 8'(game_over), 8'h0);
    checkOutput("late_level", 8'(level), 8'h1);
    applyStimulus(1'b0, 4'b0000, 2'b11);
    checkOutput("late_on_led", 8'(led), 8'h4);
    checkOutput("late_on_level", 8'(level), 8'h2);
    applyStimulus(1'b1, 4'b0000, 2'b11);
    checkOutput("pwr_show_level", 8'(level), 8'h0);
    checkOutput("pwr_show_led", 8'(led), 8'h0);

    // Reset during playback overrides a simultaneous power press.
    applyStimulus(1'b1, 4'b0000, 2'b01);
    applyStimulus(1'b0, 4'b0000, 2'b01);
    checkOutput("pre_rst_led", 8'(led), 8'h2);
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0000, 2'b01);
    rst = 1'b0;
    checkOutput("mid_rst_led", 8'(led), 8'h0);
    checkOutput("mid_rst_level", 8'(level), 8'h0);
    checkOutput("mid_rst_flags", 8'({listening, win, game_over}), 8'h0);
    applyStimulus(1'b1, 4'b0000, 2'b11);
    applyStimulus(1'b0, 4'b0000, 2'b11);
    checkOutput("fresh_level", 8'(level), 8'h1);
    checkOutput("fresh_led", 8'(led), 8'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
